// File: rtl/jtframe_dump_ctl.sv
// Dump window scheduler: counts frames on the vs falling edge and opens a
// dump window of programmable length at a chosen frame or after a trigger.
module jtframe_dump_ctl #(
  parameter int CNTW = 32,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vs,
  input  logic            arm,
  input  logic            abort,
  input  logic [CNTW-1:0] start_frame,
  input  logic [LENW-1:0] frame_len,
  input  logic            trig_en,
  input  logic            trig,
  output logic [CNTW-1:0] frame_cnt,
  output logic            dump_en,
  output logic            dump_on,
  output logic            dump_off,
  output logic            armed,
  output logic            done
);

  // state  | meaning
  // IDLE   | no window configured
  // ARMED  | configuration latched, waiting for start frame or trigger
  // ACTIVE | window open, dump_en high
  // DONE   | window closed, waiting for a new arm
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DONE} state_t;

  state_t          state, state_nx;
  logic            vs_l, trig_l;
  logic            fall, rise, start;
  logic [CNTW-1:0] start_frame_l;
  logic [LENW-1:0] frame_len_l;
  logic            trig_en_l;
  logic            trig_seen, trig_seen_nx;
  logic [LENW-1:0] win_cnt, win_cnt_nx;
  logic [LENW:0]   win_inc;
  logic            latch;
  logic            dump_en_nx, dump_on_nx, dump_off_nx;

  assign fall    = vs_l & ~vs;
  assign rise    = trig & ~trig_l;
  assign start   = fall & (trig_en_l ? (trig_seen | rise) : (frame_cnt == start_frame_l));
  assign win_inc = {1'b0, win_cnt} + 1'b1;
  assign armed   = (state == S_ARMED);
  assign done    = (state == S_DONE);

  always_comb begin
    state_nx     = state;
    dump_en_nx   = dump_en;
    dump_on_nx   = 1'b0;
    dump_off_nx  = 1'b0;
    win_cnt_nx   = win_cnt;
    trig_seen_nx = trig_seen;
    latch        = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (arm && !abort) begin
          latch        = 1'b1;
          trig_seen_nx = 1'b0;
          win_cnt_nx   = '0;
          state_nx     = S_ARMED;
        end
      end
      S_ARMED: begin
        trig_seen_nx = trig_seen | rise;
        if (abort) begin
          state_nx = S_IDLE;
        end else if (start) begin
          state_nx   = S_ACTIVE;
          dump_en_nx = 1'b1;
          dump_on_nx = 1'b1;
          win_cnt_nx = '0;
        end
      end
      S_ACTIVE: begin
        if (abort) begin
          state_nx    = S_DONE;
          dump_en_nx  = 1'b0;
          dump_off_nx = 1'b1;
        end else if (fall) begin
          if (frame_len_l != '0 && win_inc == {1'b0, frame_len_l}) begin
            state_nx    = S_DONE;
            dump_en_nx  = 1'b0;
            dump_off_nx = 1'b1;
          end
          // unlimited windows park the counter at all-ones
          if (win_cnt != '1) win_cnt_nx = win_inc[LENW-1:0];
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      vs_l          <= 1'b1;
      trig_l        <= 1'b0;
      frame_cnt     <= '0;
      start_frame_l <= '0;
      frame_len_l   <= '0;
      trig_en_l     <= 1'b0;
      trig_seen     <= 1'b0;
      win_cnt       <= '0;
      dump_en       <= 1'b0;
      dump_on       <= 1'b0;
      dump_off      <= 1'b0;
    end else begin
      state     <= state_nx;
      vs_l      <= vs;
      trig_l    <= trig;
      trig_seen <= trig_seen_nx;
      win_cnt   <= win_cnt_nx;
      dump_en   <= dump_en_nx;
      dump_on   <= dump_on_nx;
      dump_off  <= dump_off_nx;
      if (fall) frame_cnt <= frame_cnt + 1'b1;
      if (latch) begin
        start_frame_l <= start_frame;
        frame_len_l   <= frame_len;
        trig_en_l     <= trig_en;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_dump_ctl.sv
// Bench for jtframe_dump_ctl: frame-level reference model checked every cycle,
// plus literal expectations on where windows open and close.
module tb_jtframe_dump_ctl;
  localparam int CNTW = 4;
  localparam int LENW = 4;

  logic            clk = 0;
  logic            rst, vs, arm, abort, trig_en, trig;
  logic [CNTW-1:0] start_frame;
  logic [LENW-1:0] frame_len;
  logic [CNTW-1:0] frame_cnt;
  logic            dump_en, dump_on, dump_off, armed, done;

  jtframe_dump_ctl #(.CNTW(CNTW), .LENW(LENW)) dut (
    .clk(clk), .rst(rst), .vs(vs), .arm(arm), .abort(abort),
    .start_frame(start_frame), .frame_len(frame_len), .trig_en(trig_en), .trig(trig),
    .frame_cnt(frame_cnt), .dump_en(dump_en), .dump_on(dump_on), .dump_off(dump_off),
    .armed(armed), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the window in terms of frames left to run
  localparam int M_IDLE = 0, M_ARMED = 1, M_ACTIVE = 2, M_DONE = 3;
  int m_mode, m_cnt, m_left, c_start, c_len;
  bit m_vs, m_tr, m_seen, c_trig, m_on, m_off;

  always @(posedge clk) begin
    bit fall, rise;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_vs = 1; m_tr = 0; m_seen = 0;
      c_start = 0; c_len = 0; c_trig = 0; m_on = 0; m_off = 0; m_left = 0;
    end else begin
      fall = m_vs && !vs;
      rise = trig && !m_tr;
      m_on = 0; m_off = 0;
      case (m_mode)
        M_IDLE, M_DONE:
          if (arm && !abort) begin
            c_start = start_frame; c_len = frame_len; c_trig = trig_en;
            m_seen = 0; m_mode = M_ARMED;
          end
        M_ARMED:
          if (abort) m_mode = M_IDLE;
          else begin
            if (fall && (c_trig ? (m_seen || rise) : (m_cnt == c_start))) begin
              m_mode = M_ACTIVE; m_on = 1; m_left = c_len;
            end
            m_seen = m_seen | rise;
          end
        default: begin
          if (abort || (fall && c_len != 0 && m_left == 1)) begin
            m_mode = M_DONE; m_off = 1;
          end else if (fall && c_len != 0) m_left--;
        end
      endcase
      if (fall) m_cnt = (m_cnt + 1) % (1 << CNTW);
      m_vs = vs; m_tr = trig;
    end
  end

  // Compare process plus pulse bookkeeping for the literal checks
  int on_n = 0, off_n = 0, on_at = -1, off_at = -1;
  always @(posedge clk) begin
    #1;
    check("frame_cnt", frame_cnt, m_cnt);
    check("dump_en", dump_en, m_mode == M_ACTIVE);
    check("dump_on", dump_on, m_on);
    check("dump_off", dump_off, m_off);
    check("armed", armed, m_mode == M_ARMED);
    check("done", done, m_mode == M_DONE);
    if (dump_on && dump_off) check("on_off_overlap", 1, 0);
    if (dump_on) begin on_n++; on_at = frame_cnt; end
    if (dump_off) begin off_n++; off_at = frame_cnt; end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vs = 0; cycles(3);
      vs = 1; cycles(3);
    end
  endtask

  task automatic do_reset();
    rst = 1; cycles(2); rst = 0; cycles(1);
  endtask

  task automatic do_arm(input int sf, input int len, input bit te);
    start_frame = CNTW'(sf); frame_len = LENW'(len); trig_en = te;
    arm = 1; cycles(1); arm = 0;
    start_frame = '1; frame_len = '1; trig_en = ~te;
  endtask

  initial begin
    int n0, f0;
    rst = 1; vs = 1; arm = 0; abort = 0; trig_en = 0; trig = 0;
    start_frame = '0; frame_len = '0;
    do_reset();
    check("reset_cnt", frame_cnt, 0);
    check("reset_en", dump_en, 0);

    // frames without arm
    frames(5);
    check("idle_cnt", frame_cnt, 5);
    check("idle_pulses", on_n + off_n, 0);

    // frame-number start, two-frame window
    do_reset();
    do_arm(3, 2, 0);
    check("armed_lit", armed, 1);
    frames(8);
    check("w1_on_at", on_at, 4);
    check("w1_off_at", off_at, 6);
    check("w1_done", done, 1);

    // trigger mode, one-frame window
    do_arm(0, 1, 1);
    frames(2);
    check("w2_cnt", frame_cnt, 10);
    trig = 1; cycles(2); trig = 0;
    frames(3);
    check("w2_on_at", on_at, 11);
    check("w2_off_at", off_at, 12);

    // unlimited window armed past start frame: waits for the counter to wrap
    do_reset();
    frames(3);
    do_arm(1, 0, 0);
    frames(15);
    check("w3_on_at", on_at, 2);
    check("w3_en", dump_en, 1);
    frames(20);
    check("w3_still_open", dump_en, 1);
    n0 = off_n;
    abort = 1; cycles(1); abort = 0;
    check("w3_off_pulse", off_n - n0, 1);
    check("w3_done", done, 1);

    // re-arm right after DONE, then abort on the same clock as a frame edge
    do_arm(frame_cnt, 3, 0);
    frames(1);
    check("w4_en", dump_en, 1);
    vs = 0; abort = 1; cycles(1); abort = 0; cycles(2); vs = 1; cycles(3);
    check("w4_done", done, 1);

    // reset in the middle of a window
    do_arm(frame_cnt, 5, 0);
    frames(2);
    check("w5_en", dump_en, 1);
    n0 = off_n;
    rst = 1; cycles(1); rst = 0;
    check("w5_rst_en", dump_en, 0);
    check("w5_rst_cnt", frame_cnt, 0);
    check("w5_no_off", off_n - n0, 0);

    // arm+abort in IDLE is a no-op; abort in ARMED returns to IDLE silently
    n0 = on_n; f0 = off_n;
    start_frame = 1; frame_len = 1; arm = 1; abort = 1; cycles(1); arm = 0; abort = 0;
    check("arm_abort_idle", armed, 0);
    do_arm(1, 1, 0);
    arm = 1; abort = 1; cycles(1); arm = 0; abort = 0;
    check("abort_armed", armed, 0);
    frames(3);
    check("abort_no_pulses", (on_n - n0) + (off_n - f0), 0);

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtframe_dump_ctl.md
Name: jtframe_dump_ctl

Overview:
- Synthesizable scheduler for simulation and debug dumping windows.
- Counts video frames from the vertical sync and opens a dump window of programmable length starting at a chosen frame, or at the first frame after an external trigger.
- Drives the dump enable and on/off strobes used by the test harness and by on-chip capture logic.
- Sits next to the video timing in the target top level and owns the frame counter that the harness reads.

Parameters:
- CNTW, 32, width of frame counter and start_frame
- LENW, 16, width of frame_len and window frame counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- vs  in  1  vertical sync, synchronous to clk; a frame boundary is its falling edge
- arm  in  1  one-cycle request that latches the configuration and waits for the start condition
- abort  in  1  cancels an armed or active window
- start_frame  in  CNTW  frame number that opens the window when trigger mode is off
- frame_len  in  LENW  window length in frames; 0 means unlimited
- trig_en  in  1  selects trigger mode instead of start_frame, latched on arm
- trig  in  1  external trigger level (e.g. LED), rising edge detected
- frame_cnt  out  CNTW  frames seen since reset
- dump_en  out  1  high while the window is open
- dump_on  out  1  one-cycle pulse when the window opens
- dump_off  out  1  one-cycle pulse when the window closes
- armed  out  1  high in ARMED state
- done  out  1  high in DONE state

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; vs_l=1, trig_l=0; latched configuration 0; no dump_off is issued when reset lands mid-window.
- Edge detection:
  - vs_l and trig_l are registered copies of vs and trig.
  - fall = vs_l & ~vs; rise = trig & ~trig_l.
- Frame counter: on each clock with fall=1, frame_cnt <= frame_cnt+1. It wraps from 2^CNTW-1 to 0. It is never affected by state.
- Outputs: all registered. Transitions happen on the same clock edge that increments frame_cnt. Comparisons use the pre-increment frame_cnt.
- States: IDLE, ARMED, ACTIVE, DONE.
- IDLE or DONE with arm=1 and abort=0:
  - Latch start_frame, frame_len, trig_en.
  - Clear trig_seen and win_cnt.
  - Go to ARMED.
- ARMED:
  - trig_seen is set on rise and is sticky.
  - The start condition is fall & (trig_en_l ? (trig_seen | rise) : frame_cnt==start_frame_l).
  - On the start condition: go to ACTIVE, dump_en<=1, dump_on pulses 1 cycle, win_cnt<=0.
  - abort=1: go to IDLE with no pulses. abort has priority over a simultaneous start.
- ACTIVE:
  - Each fall: win_cnt<=win_cnt+1.
  - If frame_len_l!=0 and win_cnt+1==frame_len_l: go to DONE, dump_en<=0, dump_off pulses.
  - The window therefore spans exactly frame_len_l frame boundaries.
  - frame_len_l==0: win_cnt saturates at all-ones; the window stays open until abort.
  - abort=1: go to DONE, dump_en<=0, dump_off pulses. This also applies when abort coincides with fall.
- Simultaneous events and re-arm:
  - arm in ARMED or ACTIVE is ignored; changes to the configuration inputs in those states are ignored.
  - arm together with abort in IDLE/DONE: abort wins and the state is unchanged.
  - DONE holds done=1 until arm starts a new cycle. Re-arm is allowed on the clock directly after entering DONE.
- Pulse rules: dump_on and dump_off are never high in the same cycle; each is exactly 1 cycle wide.
- Latency: dump_en rises 1 clock after the first clk sample with vs low following vs high.
- start_frame already passed when arm arrives: wait for frame_cnt to wrap back around. No error is raised.

Test Plan:
- Reset, then 5 vs pulses with arm never asserted -> frame_cnt=5, dump_en stays 0, no dump_on/dump_off pulses.
- arm with start_frame=3, frame_len=2, trig_en=0; run 8 frames -> dump_on at the fall where frame_cnt goes 3->4; dump_off at the fall 5->6; dump_en high across exactly 2 boundaries; done=1.
- arm with trig_en=1, frame_len=1; trig rises mid-frame 10 -> dump_on at the next fall (frame_cnt 10->11); dump_off at the fall 11->12.
- frame_len=0, start_frame=1 -> window stays open for 20 frames; abort -> dump_off pulses 1 cycle, state DONE.
- Mid-window events: rst asserted while dump_en=1 -> all outputs 0 next clock, no dump_off. abort and arm together in ARMED -> state IDLE, no pulses.
- Force frame_cnt near 2^CNTW-1 (use CNTW=4): start_frame=1 armed at frame_cnt=3 -> counter wraps 15->0, window opens at the fall 1->2.
